// File: rtl/controller.sv
// -----------------------------------------------------------------------------
// controller -- multi-cycle instruction sequencer for a small 8-bit datapath.
//
// Fetches 16-bit instructions from an external instruction port. It decodes
// each one and drives the register file, the op2 register, the immediate path
// and the ALU through a fixed state sequence:
//   IDLE -> FETCH -> DECODE -> [LD_OP2] -> [EXEC -> WB] -> FETCH ... -> HALT
//
// Instruction word: [15:12] opcode, [11:8] rd, [7:0] imm8, [3:0] rs.
// Register file has 5 entries (r0..r4).
//
// Ports
//   clk, rst          clock (rising edge), asynchronous active-high reset
//   start             leaves IDLE; ignored in every other state
//   pc, instr_req     fetch address / request (request is high in FETCH)
//   instr, instr_valid  fetched word, accepted in FETCH when instr_valid=1
//   r_wf, en_rf       register-file write strobe (1 = write) and enable
//   en_reg            op2 register load
//   en_alu            ALU result register load
//   en_imm, imm       immediate enable and value
//   sel_alu           000 PASS, 001 ADD, 010 SUB, 011 AND, 100 OR
//   sel_rf            register-file address
//   sel_mux           ALU in1 source (1 = immediate, 0 = register file)
//   alu_zero          zero flag of the ALU result, captured in WB
//   alu_out           ALU result, monitor only
//   busy, halted      status: busy outside IDLE/HALT, halted in HALT
//   illegal           sticky illegal-instruction flag
//
// Build option
//   CTRL_ILLEGAL_TRAP_EN  when defined, an illegal instruction halts the
//                         controller and sets illegal (sticky until rst).
//                         When undefined, an illegal instruction executes as a
//                         NOP and illegal is tied to 0.
// -----------------------------------------------------------------------------
module controller (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  output logic [7:0]  pc,
  output logic        instr_req,
  input  logic [15:0] instr,
  input  logic        instr_valid,
  output logic        r_wf,
  output logic        en_rf,
  output logic        en_reg,
  output logic        en_alu,
  output logic        en_imm,
  output logic [7:0]  imm,
  output logic [2:0]  sel_alu,
  output logic [3:0]  sel_rf,
  output logic        sel_mux,
  input  logic        alu_zero,
  input  logic [7:0]  alu_out,
  output logic        busy,
  output logic        halted,
  output logic        illegal
);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_DECODE, S_LD_OP2, S_EXEC, S_WB, S_HALT
  } state_t;

  localparam logic [3:0] OP_NOP  = 4'h0;
  localparam logic [3:0] OP_LDI  = 4'h1;
  localparam logic [3:0] OP_ADD  = 4'h2;
  localparam logic [3:0] OP_SUB  = 4'h3;
  localparam logic [3:0] OP_AND  = 4'h4;
  localparam logic [3:0] OP_OR   = 4'h5;
  localparam logic [3:0] OP_JZ   = 4'h6;
  localparam logic [3:0] OP_JMP  = 4'h7;
  localparam logic [3:0] OP_HALT = 4'hF;

  localparam logic [2:0] ALU_PASS = 3'b000;
  localparam logic [2:0] ALU_ADD  = 3'b001;
  localparam logic [2:0] ALU_SUB  = 3'b010;
  localparam logic [2:0] ALU_AND  = 3'b011;
  localparam logic [2:0] ALU_OR   = 3'b100;

  localparam logic [3:0] REG_MAX = 4'd4;

  // Every datapath-facing output lives in one registered bundle so that a
  // single '0 covers both reset and "nothing named for this state".
  typedef struct packed {
    logic       instr_req;
    logic       r_wf;
    logic       en_rf;
    logic       en_reg;
    logic       en_alu;
    logic       en_imm;
    logic [7:0] imm;
    logic [2:0] sel_alu;
    logic [3:0] sel_rf;
    logic       sel_mux;
    logic       busy;
    logic       halted;
  } ctrl_t;

  state_t      state_q, state_d;
  logic [7:0]  pc_q, pc_d;
  logic [15:0] instr_q, instr_d;
  logic        zflag_q, zflag_d;
  ctrl_t       ctrl_q, ctrl_d;
`ifdef CTRL_ILLEGAL_TRAP_EN
  logic        illegal_q, illegal_d;
`endif

  // alu_out is observation-only; fold it into a sink so it stays connected.
  logic unused_alu_out;
  assign unused_alu_out = ^alu_out;

  // ---------------------------------------------------------------------------
  // Decode of the latched instruction
  // ---------------------------------------------------------------------------
  logic [3:0] op, rd, rs;
  logic [7:0] imm8;
  logic       is_alu, ill;

  assign op   = instr_q[15:12];
  assign rd   = instr_q[11:8];
  assign imm8 = instr_q[7:0];
  assign rs   = instr_q[3:0];

  assign is_alu = (op == OP_ADD) || (op == OP_SUB) || (op == OP_AND) || (op == OP_OR);

  // rd is only a register for LDI and ALU ops; rs only for ALU ops. For jumps
  // the same bits are part of imm8 and must not be range-checked.
  always_comb begin
    ill = 1'b0;
    if (op inside {[4'h8:4'hE]})                   ill = 1'b1;
    if ((op == OP_LDI || is_alu) && rd > REG_MAX)  ill = 1'b1;
    if (is_alu && rs > REG_MAX)                    ill = 1'b1;
  end

  function automatic logic [2:0] alu_sel(input logic [3:0] opc);
    logic [2:0] s;
    case (opc)
      OP_ADD:  s = ALU_ADD;
      OP_SUB:  s = ALU_SUB;
      OP_AND:  s = ALU_AND;
      OP_OR:   s = ALU_OR;
      default: s = ALU_PASS;
    endcase
    return s;
  endfunction

  // ---------------------------------------------------------------------------
  // Next state, then outputs for the state being entered. Outputs are
  // registered, so they are computed from state_d and appear during that state.
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    zflag_d = zflag_q;
`ifdef CTRL_ILLEGAL_TRAP_EN
    illegal_d = illegal_q;
`endif

    case (state_q)
      S_IDLE: begin
        if (start) state_d = S_FETCH;
      end
      S_FETCH: begin
        if (instr_valid) begin
          instr_d = instr;
          state_d = S_DECODE;
        end
      end
      S_DECODE: begin
        if (ill) begin
`ifdef CTRL_ILLEGAL_TRAP_EN
          illegal_d = 1'b1;
          state_d   = S_HALT;
`else
          pc_d    = pc_q + 8'd1;
          state_d = S_FETCH;
`endif
        end else begin
          case (op)
            OP_NOP: begin
              pc_d    = pc_q + 8'd1;
              state_d = S_FETCH;
            end
            OP_LDI:                         state_d = S_EXEC;
            OP_ADD, OP_SUB, OP_AND, OP_OR:  state_d = S_LD_OP2;
            OP_JZ: begin
              // zflag_q only changes in WB, so this sees the most recent WB.
              pc_d    = zflag_q ? imm8 : pc_q + 8'd1;
              state_d = S_FETCH;
            end
            OP_JMP: begin
              pc_d    = imm8;
              state_d = S_FETCH;
            end
            OP_HALT:                        state_d = S_HALT;
            default: begin
              pc_d    = pc_q + 8'd1;
              state_d = S_FETCH;
            end
          endcase
        end
      end
      S_LD_OP2: state_d = S_EXEC;
      S_EXEC:   state_d = S_WB;
      S_WB: begin
        zflag_d = alu_zero;
        pc_d    = pc_q + 8'd1;
        state_d = S_FETCH;
      end
      S_HALT:   state_d = S_HALT;
      default:  state_d = S_IDLE;
    endcase

    ctrl_d = '0;
    case (state_d)
      S_FETCH: ctrl_d.instr_req = 1'b1;
      S_LD_OP2: begin
        ctrl_d.sel_rf = rs;
        ctrl_d.en_reg = 1'b1;
      end
      S_EXEC: begin
        ctrl_d.en_alu = 1'b1;
        if (op == OP_LDI) begin
          ctrl_d.sel_mux = 1'b1;
          ctrl_d.en_imm  = 1'b1;
          ctrl_d.imm     = imm8;
          ctrl_d.sel_alu = ALU_PASS;
        end else begin
          ctrl_d.sel_rf  = rd;
          ctrl_d.sel_alu = alu_sel(op);
        end
      end
      S_WB: begin
        ctrl_d.sel_rf = rd;
        ctrl_d.r_wf   = 1'b1;
        ctrl_d.en_rf  = 1'b1;
      end
      S_HALT:  ctrl_d.halted = 1'b1;
      default: ;
    endcase
    ctrl_d.busy = (state_d != S_IDLE) && (state_d != S_HALT);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      pc_q    <= 8'h00;
      instr_q <= 16'h0000;
      zflag_q <= 1'b0;
      ctrl_q  <= '0;
`ifdef CTRL_ILLEGAL_TRAP_EN
      illegal_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
      zflag_q <= zflag_d;
      ctrl_q  <= ctrl_d;
`ifdef CTRL_ILLEGAL_TRAP_EN
      illegal_q <= illegal_d;
`endif
    end
  end

  assign pc        = pc_q;
  assign instr_req = ctrl_q.instr_req;
  assign r_wf      = ctrl_q.r_wf;
  assign en_rf     = ctrl_q.en_rf;
  assign en_reg    = ctrl_q.en_reg;
  assign en_alu    = ctrl_q.en_alu;
  assign en_imm    = ctrl_q.en_imm;
  assign imm       = ctrl_q.imm;
  assign sel_alu   = ctrl_q.sel_alu;
  assign sel_rf    = ctrl_q.sel_rf;
  assign sel_mux   = ctrl_q.sel_mux;
  assign busy      = ctrl_q.busy;
  assign halted    = ctrl_q.halted;
`ifdef CTRL_ILLEGAL_TRAP_EN
  assign illegal   = illegal_q;
`else
  assign illegal   = 1'b0;
`endif

endmodule

// File: tb/tb_controller.sv
// Testbench for controller: instruction memory responder, small datapath
// model (5-entry RF, op2 register, registered ALU), and a fetch scoreboard.
// Each expected fetch (pc, cycles since previous fetch) is queued by the
// stimulus; the monitor pops and compares whenever a fetch is presented.
module tb_controller;
  logic        clk = 1'b0;
  logic        rst, start;
  logic [7:0]  pc;
  logic        instr_req;
  logic [15:0] instr = 16'h0000;
  logic        instr_valid = 1'b0;
  logic        r_wf, en_rf, en_reg, en_alu, en_imm;
  logic [7:0]  imm;
  logic [2:0]  sel_alu;
  logic [3:0]  sel_rf;
  logic        sel_mux;
  logic        alu_zero;
  logic [7:0]  alu_out;
  logic        busy, halted, illegal;

  controller dut (
    .clk(clk), .rst(rst), .start(start), .pc(pc), .instr_req(instr_req),
    .instr(instr), .instr_valid(instr_valid), .r_wf(r_wf), .en_rf(en_rf),
    .en_reg(en_reg), .en_alu(en_alu), .en_imm(en_imm), .imm(imm),
    .sel_alu(sel_alu), .sel_rf(sel_rf), .sel_mux(sel_mux),
    .alu_zero(alu_zero), .alu_out(alu_out), .busy(busy), .halted(halted),
    .illegal(illegal)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Every output packed together; all must be zero in reset.
  logic [32:0] outs;
  assign outs = {pc, instr_req, r_wf, en_rf, en_reg, en_alu, en_imm, imm,
                 sel_alu, sel_rf, sel_mux, busy, halted, illegal};
  logic [4:0] enables;
  assign enables = {r_wf, en_rf, en_reg, en_alu, en_imm};

  // ---------------- datapath model ----------------
  logic [7:0] rf [0:4];
  logic [7:0] op2_q, alu_q, rd_data, in1;
  assign rd_data  = (sel_rf < 4'd5) ? rf[sel_rf[2:0]] : 8'h00;
  assign in1      = sel_mux ? imm : rd_data;
  assign alu_zero = (alu_q == 8'h00);
  assign alu_out  = alu_q;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 5; i++) rf[i] <= 8'h00;
      op2_q <= 8'h00;
      alu_q <= 8'h00;
    end else begin
      if (en_reg) op2_q <= rd_data;
      if (en_alu) begin
        case (sel_alu)
          3'b000:  alu_q <= in1;
          3'b001:  alu_q <= in1 + op2_q;
          3'b010:  alu_q <= in1 - op2_q;
          3'b011:  alu_q <= in1 & op2_q;
          3'b100:  alu_q <= in1 | op2_q;
          default: alu_q <= 8'h00;
        endcase
      end
      if (en_rf && r_wf && sel_rf < 4'd5) rf[sel_rf[2:0]] <= alu_q;
    end
  end

  // ---------------- instruction memory responder ----------------
  logic [15:0] imem [0:255];
  logic        stall = 1'b0;
  always @(posedge clk) begin
    #2;
    if (instr_req && !stall) begin
      instr       = imem[pc];
      instr_valid = 1'b1;
    end else begin
      instr       = 16'h0000;
      instr_valid = 1'b0;
    end
  end

  // ---------------- scoreboard + monitor ----------------
  typedef struct { logic [7:0] pc; int gap; } fetch_t;
  fetch_t exp_q[$];
  fetch_t mon_e;
  int     last_fire = 0;

  always @(negedge clk) begin
    if (!rst && instr_req && instr_valid) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL fetch_unexpected: got pc %0h expected no fetch", pc);
      end else begin
        mon_e = exp_q.pop_front();
        chk("fetch_pc", 64'(pc), 64'(mon_e.pc));
        if (mon_e.gap != 0) chk("fetch_gap", 64'(cyc - last_fire), 64'(mon_e.gap));
      end
      last_fire = cyc;
    end
  end

  task automatic expf(input logic [7:0] p, input int g);
    fetch_t e;
    e.pc  = p;
    e.gap = g;
    exp_q.push_back(e);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    exp_q.delete();
    for (int i = 0; i < 256; i++) imem[i] = 16'hF000;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_halt(input string name, input int budget);
    int i = 0;
    while (!halted && i < budget) begin
      @(negedge clk);
      i++;
    end
    n_cmp++;
    if (!halted) begin
      n_bad++;
      $display("FAIL %s_timeout: halted 0 expected 1 within %0d cycles", name, budget);
    end
    chk({name, "_queue_left"}, 64'(exp_q.size()), 64'd0);
    exp_q.delete();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int i;
    rst = 1'b1;
    start = 1'b0;
    for (int k = 0; k < 256; k++) imem[k] = 16'hF000;
    @(negedge clk);
    @(negedge clk);
    chk("reset_outputs", 64'(outs), 64'd0);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    chk("idle_without_start", 64'({instr_req, busy, pc}), 64'd0);

    // Program A: LDI r0,5; LDI r1,3; SUB r0,r1; HALT
    do_reset();
    imem[0] = 16'h1005; imem[1] = 16'h1103; imem[2] = 16'h3001; imem[3] = 16'hF000;
    expf(8'h00, 0); expf(8'h01, 4); expf(8'h02, 4); expf(8'h03, 5);
    pulse_start();
    wait_halt("progA", 100);
    chk("progA_r0", 64'(rf[0]), 64'h02);
    chk("progA_r1", 64'(rf[1]), 64'h03);
    chk("progA_pc_busy", 64'({pc, busy, halted}), 64'({8'h03, 1'b0, 1'b1}));
    pulse_start();
    repeat (3) @(negedge clk);
    chk("halt_terminal", 64'({pc, instr_req, halted, enables}), 64'({8'h03, 1'b0, 1'b1, 5'b0}));

    // Program B: JZ taken / not taken, JMP, AND, OR, ADD, NOP
    do_reset();
    imem[8'h00] = 16'h1200; imem[8'h01] = 16'h6010;
    imem[8'h10] = 16'h1201; imem[8'h11] = 16'h6010; imem[8'h12] = 16'h7020;
    imem[8'h20] = 16'h130C; imem[8'h21] = 16'h140A; imem[8'h22] = 16'h4304;
    imem[8'h23] = 16'h5403; imem[8'h24] = 16'h2402; imem[8'h25] = 16'h0000;
    imem[8'h26] = 16'hF000;
    expf(8'h00, 0); expf(8'h01, 4); expf(8'h10, 2); expf(8'h11, 4); expf(8'h12, 2);
    expf(8'h20, 2); expf(8'h21, 4); expf(8'h22, 4); expf(8'h23, 5); expf(8'h24, 5);
    expf(8'h25, 5); expf(8'h26, 2);
    pulse_start();
    wait_halt("progB", 200);
    chk("progB_r2", 64'(rf[2]), 64'h01);
    chk("progB_r3_and", 64'(rf[3]), 64'h08);
    chk("progB_r4_or_add", 64'(rf[4]), 64'h0B);
    chk("progB_pc", 64'(pc), 64'h26);

    // FETCH stall: instr_valid withheld for 5 cycles
    do_reset();
    imem[0] = 16'h0000; imem[1] = 16'hF000;
    expf(8'h00, 0); expf(8'h01, 2);
    stall = 1'b1;
    pulse_start();
    for (int k = 0; k < 5; k++) begin
      chk("stall_fetch", 64'({instr_req, pc, enables, busy}), 64'({1'b1, 8'h00, 5'b0, 1'b1}));
      @(negedge clk);
    end
    stall = 1'b0;
    wait_halt("stall", 50);

    // pc wrap FF -> 00, JZ not taken on reset zflag, then taken
    do_reset();
    imem[8'h00] = 16'h6040; imem[8'h01] = 16'h1000; imem[8'h02] = 16'h70FF;
    imem[8'hFF] = 16'h0000; imem[8'h40] = 16'hF000;
    expf(8'h00, 0); expf(8'h01, 2); expf(8'h02, 4); expf(8'hFF, 2);
    expf(8'h00, 2); expf(8'h40, 2);
    pulse_start();
    wait_halt("wrap", 100);
    chk("wrap_pc", 64'(pc), 64'h40);

    // Reset in the middle of EXEC of an ADD at pc 1
    do_reset();
    imem[0] = 16'h0000; imem[1] = 16'h2001;
    expf(8'h00, 0); expf(8'h01, 2);
    pulse_start();
    i = 0;
    while (!en_alu && i < 30) begin
      @(negedge clk);
      i++;
    end
    chk("mid_exec_reached", 64'({en_alu, pc}), 64'({1'b1, 8'h01}));
    rst = 1'b1;
    #1;
    chk("rst_mid_exec_outputs", 64'(outs), 64'd0);
    chk("rst_mid_exec_queue", 64'(exp_q.size()), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    chk("post_rst_idle", 64'({instr_req, busy, pc}), 64'd0);
    imem[0] = 16'hF000;
    expf(8'h00, 0);
    pulse_start();
    wait_halt("restart", 50);
    chk("restart_pc", 64'(pc), 64'h00);

    // Illegal opcode 8, then illegal rd=7
    do_reset();
    imem[0] = 16'h8000;
    expf(8'h00, 0);
`ifndef CTRL_ILLEGAL_TRAP_EN
    expf(8'h01, 2);
`endif
    pulse_start();
    wait_halt("ill_op", 50);
`ifdef CTRL_ILLEGAL_TRAP_EN
    chk("ill_op_trap", 64'({pc, illegal}), 64'({8'h00, 1'b1}));
`else
    chk("ill_op_nop", 64'({pc, illegal}), 64'({8'h01, 1'b0}));
`endif

    do_reset();
    imem[0] = 16'h1705;
    expf(8'h00, 0);
`ifndef CTRL_ILLEGAL_TRAP_EN
    expf(8'h01, 2);
`endif
    pulse_start();
    wait_halt("ill_rd", 50);
`ifdef CTRL_ILLEGAL_TRAP_EN
    chk("ill_rd_trap", 64'({pc, illegal}), 64'({8'h00, 1'b1}));
`else
    chk("ill_rd_nop", 64'({pc, illegal}), 64'({8'h01, 1'b0}));
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
